// File: rtl/control_sequencer.sv
// Instruction sequencer: captures an instruction word, decodes its opcode and
// steps a 4-bit state code through the execute steps for the downstream decoder.
module control_sequencer #(
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic [IW-1:0] din,
  input  logic          stall,
  output logic [3:0]    state,
  output logic [IW-1:0] instr,
  output logic          busy,
  output logic          done,
  output logic          illegal
);

  // state   | meaning
  // IDLE    | waiting for run; done/illegal pulses appear here
  // DECODE  | opcode decode, picks first execute step
  // LOAD    | single-step load
  // MOVE    | single-step move
  // LDPC    | single-step ldpc
  // BRANCH  | single-step branch
  // SUB0..2 | three-step subtract
  // ADD0..2 | three-step add
  // XOR0..2 | three-step xor
  // INVALID | never produced; falls back to IDLE
  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0000,
    ST_DECODE  = 4'b0001,
    ST_LOAD    = 4'b0010,
    ST_MOVE    = 4'b0011,
    ST_LDPC    = 4'b0100,
    ST_BRANCH  = 4'b0101,
    ST_SUB0    = 4'b0110,
    ST_SUB1    = 4'b0111,
    ST_SUB2    = 4'b1000,
    ST_ADD0    = 4'b1001,
    ST_ADD1    = 4'b1010,
    ST_ADD2    = 4'b1011,
    ST_XOR0    = 4'b1100,
    ST_XOR1    = 4'b1101,
    ST_XOR2    = 4'b1110,
    ST_INVALID = 4'b1111
  } state_t;

  localparam logic [3:0] OP_LOAD   = 4'b0000;
  localparam logic [3:0] OP_MOVE   = 4'b0001;
  localparam logic [3:0] OP_LDPC   = 4'b0010;
  localparam logic [3:0] OP_BRANCH = 4'b0011;
  localparam logic [3:0] OP_ADD    = 4'b0100;
  localparam logic [3:0] OP_SUB    = 4'b0101;
  localparam logic [3:0] OP_XOR    = 4'b0110;

  state_t        state_q, state_next;
  logic [IW-1:0] ir_q;
  logic          ir_load;
  logic          done_q, done_next;
  logic          illegal_q, illegal_next;
  logic [3:0]    opcode;

  assign opcode = ir_q[15:12];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ir_q      <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_next;
      done_q    <= done_next;
      illegal_q <= illegal_next;
      if (ir_load) ir_q <= din;
    end
  end

  // Pulses default low, so a stall starting in the pulse cycle still clears them.
  always_comb begin
    state_next   = state_q;
    ir_load      = 1'b0;
    done_next    = 1'b0;
    illegal_next = 1'b0;
    if (!stall) begin
      unique case (state_q)
        ST_IDLE: begin
          if (run) begin
            ir_load    = 1'b1;
            state_next = ST_DECODE;
          end
        end
        ST_DECODE: begin
          unique case (opcode)
            OP_LOAD:   state_next = ST_LOAD;
            OP_MOVE:   state_next = ST_MOVE;
            OP_LDPC:   state_next = ST_LDPC;
            OP_BRANCH: state_next = ST_BRANCH;
            OP_ADD:    state_next = ST_ADD0;
            OP_SUB:    state_next = ST_SUB0;
            OP_XOR:    state_next = ST_XOR0;
            default: begin
              state_next   = ST_IDLE;
              illegal_next = 1'b1;
            end
          endcase
        end
        ST_LOAD, ST_MOVE, ST_LDPC, ST_BRANCH,
        ST_SUB2, ST_ADD2, ST_XOR2: begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
        ST_SUB0: state_next = ST_SUB1;
        ST_SUB1: state_next = ST_SUB2;
        ST_ADD0: state_next = ST_ADD1;
        ST_ADD1: state_next = ST_ADD2;
        ST_XOR0: state_next = ST_XOR1;
        ST_XOR1: state_next = ST_XOR2;
        default: state_next = ST_IDLE;
      endcase
    end
    if (state_q == ST_INVALID) state_next = ST_IDLE;
  end

  assign state   = state_q;
  assign instr   = ir_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer against a trace-based reference model
// that expands each accepted opcode into its list of step codes.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, stall;
  logic [15:0] din;
  logic [3:0]  state;
  logic [15:0] instr;
  logic        busy, done, illegal;

  int checks = 0;
  int failures = 0;

  control_sequencer #(.IW(16)) dut (
    .clk(clk), .reset(reset), .run(run), .din(din), .stall(stall),
    .state(state), .instr(instr), .busy(busy), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // reference model: current code, IR, pulses, and the remaining step codes
  logic [3:0]  m_state;
  logic [15:0] m_instr;
  logic        m_done, m_ill, m_bad;
  int          steps[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic load_steps(input logic [3:0] op);
    steps.delete();
    case (op)
      4'd0: steps.push_back(2);
      4'd1: steps.push_back(3);
      4'd2: steps.push_back(4);
      4'd3: steps.push_back(5);
      4'd4: begin steps.push_back(9);  steps.push_back(10); steps.push_back(11); end
      4'd5: begin steps.push_back(6);  steps.push_back(7);  steps.push_back(8);  end
      4'd6: begin steps.push_back(12); steps.push_back(13); steps.push_back(14); end
      default: ;
    endcase
  endtask

  task automatic model_step(input logic r, input logic rn, input logic [15:0] d, input logic st);
    if (r) begin
      m_state = 0; m_instr = 0; m_done = 0; m_ill = 0; m_bad = 0;
      steps.delete();
    end else begin
      m_done = 0;
      m_ill  = 0;
      if (!st) begin
        if (m_state == 0) begin
          if (rn) begin
            m_instr = d;
            m_state = 1;
            load_steps(d[15:12]);
            m_bad = (steps.size() == 0);
          end
        end else if (steps.size() > 0) begin
          m_state = 4'(steps.pop_front());
        end else begin
          m_state = 0;
          if (m_bad) m_ill = 1; else m_done = 1;
        end
      end
    end
  endtask

  // one clock: drive at negedge, advance model, compare at next negedge
  task automatic cyc(input logic r, input logic rn, input logic [15:0] d, input logic st);
    reset = r; run = rn; din = d; stall = st;
    model_step(r, rn, d, st);
    @(negedge clk);
    check("state",   32'(state),   32'(m_state));
    check("instr",   32'(instr),   32'(m_instr));
    check("busy",    32'(busy),    32'(m_state != 0));
    check("done",    32'(done),    32'(m_done));
    check("illegal", 32'(illegal), 32'(m_ill));
  endtask

  initial begin
    m_state = 0; m_instr = 0; m_done = 0; m_ill = 0; m_bad = 0;
    cyc(1, 0, 16'h0, 0);
    cyc(1, 1, 16'hFFFF, 1);
    check("reset_state", 32'(state), 32'h0);
    check("reset_instr", 32'(instr), 32'h0);

    // add: five-cycle latency, run/din noise while busy
    cyc(0, 1, 16'h4120, 0);
    repeat (4) cyc(0, 0, 16'(($urandom)), 0);
    check("add_done", 32'(done), 32'h1);
    cyc(0, 0, 16'h0, 0);

    // load then move back to back
    cyc(0, 1, 16'h0345, 0);
    cyc(0, 1, 16'h9999, 0);
    cyc(0, 0, 16'h0, 0);
    check("load_done", 32'(done), 32'h1);
    cyc(0, 1, 16'h1230, 0);
    check("move_instr", 32'(instr), 32'h1230);
    repeat (3) cyc(0, 0, 16'h0, 0);

    // sub with two stall cycles in SUB1
    cyc(0, 1, 16'h5210, 0);
    cyc(0, 0, 16'h0, 0);
    cyc(0, 0, 16'h0, 0);
    cyc(0, 1, 16'h0, 1);
    cyc(0, 0, 16'h0, 1);
    check("sub_stall_hold", 32'(state), 32'h7);
    cyc(0, 0, 16'h0, 0);
    cyc(0, 0, 16'h0, 0);
    check("sub_done", 32'(done), 32'h1);

    // illegal opcode, stall in the pulse cycle
    cyc(0, 1, 16'hF000, 0);
    cyc(0, 0, 16'h0, 0);
    check("illegal_pulse", 32'(illegal), 32'h1);
    cyc(0, 0, 16'h0, 1);
    check("illegal_drop", 32'(illegal), 32'h0);

    // xor interrupted by reset in XOR1
    cyc(0, 1, 16'h6120, 0);
    cyc(0, 1, 16'h7777, 0);
    cyc(0, 0, 16'h0, 0);
    check("xor1", 32'(state), 32'hD);
    cyc(1, 0, 16'h0, 0);
    cyc(0, 0, 16'h0, 0);

    // run with stall in IDLE is ignored
    cyc(0, 1, 16'hABCD, 1);
    check("stall_idle", 32'(state), 32'h0);

    for (int i = 0; i < 3000; i++) begin
      logic [15:0] d;
      d = 16'($urandom);
      if ($urandom_range(0, 3) == 0) d[15] = 1'b0;
      cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 1) == 1), d,
          ($urandom_range(0, 4) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Upstream stage of the control output decoder.
- Captures the instruction word into an instruction register when `run` is asserted.
- Decodes the opcode and walks the 4-bit `state` code through the execute steps of that instruction; the downstream decoder turns each code into datapath control strobes.
- Reports `busy`, `done` and `illegal` status to the top-level CPU wrapper.

Parameters:
- IW, 16, instruction width. Field positions are fixed: opcode = [15:12], rx = [11:8], ry = [7:4]. IW must be 16.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- run  input  1  start request; sampled only in IDLE.
- din  input  16  instruction word; captured into IR when `run` is accepted.
- stall  input  1  freezes the sequencer: `state` and IR hold their values.
- state  output  4  current step code; feeds the decoder.
- instr  output  16  instruction register contents; feeds the decoder.
- busy  output  1  high whenever `state` is not IDLE.
- done  output  1  one-cycle pulse when an instruction completes.
- illegal  output  1  one-cycle pulse when an undefined opcode is decoded.

Behaviour:
- Reset: synchronous and active-high; applies regardless of `stall` or current state, including mid-instruction. On reset: `state` = 4'b0000, `instr` = 16'h0000, `done` = 0, `illegal` = 0, `busy` = 0.
- State codes:
  - IDLE = 0000, DECODE = 0001.
  - LOAD = 0010, MOVE = 0011, LDPC = 0100, BRANCH = 0101.
  - SUB0/1/2 = 0110/0111/1000.
  - ADD0/1/2 = 1001/1010/1011.
  - XOR0/1/2 = 1100/1101/1110.
  - Code 1111 is never produced. If reached, it goes to IDLE on the next edge with no pulses.
- Opcode map (`instr[15:12]`): 0000 load, 0001 move, 0010 ldpc, 0011 branch, 0100 add, 0101 sub, 0110 xor. Codes 0111–1111 are illegal.
- IDLE: if `run` and not `stall`, then IR <= `din` and next state = DECODE. Otherwise hold.
- DECODE: next state is the first execute state of the opcode:
  - load -> LOAD, move -> MOVE, ldpc -> LDPC, branch -> BRANCH, add -> ADD0, sub -> SUB0, xor -> XOR0.
  - Illegal opcode: next state = IDLE, `illegal` = 1 for the following cycle, `done` stays 0.
- Single-step states (LOAD, MOVE, LDPC, BRANCH): next state = IDLE, `done` = 1 for the following cycle.
- Three-step sequences advance X0 -> X1 -> X2 one per cycle. From X2, next state = IDLE and `done` = 1 for the following cycle.
- `done` and `illegal` are registered pulses, high exactly in the first IDLE cycle after completion.
- Back-to-back instructions: `run` in that same IDLE cycle is accepted. `done` is still a single cycle.
- Latency from accepted `run` to `done`:
  - single-step instructions: 3 cycles;
  - three-step instructions: 5 cycles;
  - illegal opcodes: 2 cycles to the `illegal` pulse.
- Stall:
  - While `stall` = 1, `state` and IR hold. `run` is ignored, even if `run` = 1 in IDLE in that cycle.
  - `done`/`illegal` are pulses, so if stall begins in the pulse cycle they still drop after one cycle.
  - Progress resumes on the first edge with `stall` = 0.
- IR stability: IR changes only on acceptance in IDLE or on reset. `run`/`din` activity while `busy` is ignored.
- `busy` is combinational from `state` (`state` != 0000).

Test Plan:
- Reset then `run`=1, `din`=16'h4120 (add r1,r2): `state` sequence 0001, 1001, 1010, 1011, 0000; `done`=1 in that 0000 cycle only; `instr`=16'h4120 throughout.
- `din`=16'h0345 (load): `state` 0001, 0010, 0000; `done` at cycle 3. Then `run` held high with `din`=16'h1230 in the `done` cycle: MOVE (0011) follows with no idle gap, `instr` updates to 16'h1230.
- `din`=16'h5210 (sub), `stall`=1 for 2 cycles while in 0111: `state` stays 0111 for 3 cycles total, then 1000, 0000; `done` at cycle 7.
- `din`=16'hF000: `state` 0001, 0000; `illegal`=1 for one cycle, `done`=0.
- `din`=16'h6120 (xor), `reset`=1 while `state`=1101: next edge `state`=0000, `instr`=0, no `done`. `run`/`din` changes while `busy` do not alter `instr`.
- `run` pulsed with `stall`=1 in IDLE: no capture, `state` remains 0000.
